// File: rtl/icache_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | icache_pkg : shared FSM encoding and width helper for instr_cache         |
// | Revision   : 1.0                                                          |
// +---------------------------------------------------------------------------+
package icache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_READ = 2'd1,
    ST_UPDATE   = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_cache_array.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | instr_cache_array : valid/tag/data storage with combinational lookup      |
// | Revision          : 1.0                                                   |
// +---------------------------------------------------------------------------+
module instr_cache_array #(
  parameter int NUM_BLOCKS      = 8,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int TAG_W           = 3,
  parameter int IDX_W           = 3,
  parameter int OFF_W           = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [IDX_W-1:0]             lk_index,
  input  logic [TAG_W-1:0]             lk_tag,
  input  logic [OFF_W-1:0]             lk_offset,
  output logic                         lk_hit,
  output logic [31:0]                  lk_word,
  input  logic                         fill_en,
  input  logic [IDX_W-1:0]             fill_index,
  input  logic [TAG_W-1:0]             fill_tag,
  input  logic [32*WORDS_PER_BLOCK-1:0] fill_data,
  input  logic                         clear_all
);

  logic [NUM_BLOCKS-1:0]                valid_q, valid_d;
  logic [TAG_W-1:0]                     tag_q  [NUM_BLOCKS];
  logic [TAG_W-1:0]                     tag_d  [NUM_BLOCKS];
  logic [WORDS_PER_BLOCK-1:0][31:0]     data_q [NUM_BLOCKS];
  logic [WORDS_PER_BLOCK-1:0][31:0]     data_d [NUM_BLOCKS];

  // Fill and clear are never requested together: clear only happens in IDLE.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (clear_all) begin
      valid_d = '0;
    end else if (fill_en) begin
      valid_d[fill_index] = 1'b1;
      tag_d[fill_index]   = fill_tag;
      data_d[fill_index]  = fill_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign lk_hit  = valid_q[lk_index] && (tag_q[lk_index] == lk_tag);
  assign lk_word = data_q[lk_index][lk_offset];

endmodule
`default_nettype wire

// File: rtl/instr_cache.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | instr_cache : direct-mapped read-only instruction cache, stalling fetch   |
// | Revision    : 1.0                                                         |
// +---------------------------------------------------------------------------+
module instr_cache
  import icache_pkg::*;
#(
  parameter  int ADDR_WIDTH      = 10,
  parameter  int NUM_BLOCKS      = 8,
  parameter  int WORDS_PER_BLOCK = 4,
  parameter  int COUNT_WIDTH     = 16,
  localparam int OFF_W           = clog2(WORDS_PER_BLOCK),
  localparam int IDX_W           = clog2(NUM_BLOCKS),
  localparam int TAG_W           = ADDR_WIDTH - 2 - OFF_W - IDX_W,
  localparam int BLK_W           = ADDR_WIDTH - 2 - OFF_W
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [ADDR_WIDTH-1:0]         ADDRESS,
  input  logic                          READ,
  input  logic                          FLUSH,
  output logic [31:0]                   INSTRUCTION,
  output logic                          BUSYWAIT,
  output logic                          MEM_READ,
  output logic [BLK_W-1:0]              MEM_ADDRESS,
  input  logic [32*WORDS_PER_BLOCK-1:0] MEM_READDATA,
  input  logic                          MEM_BUSYWAIT,
  output logic [COUNT_WIDTH-1:0]        HIT_COUNT,
  output logic [COUNT_WIDTH-1:0]        MISS_COUNT
);

  state_e                 state_q, state_d;
  logic [BLK_W-1:0]       miss_blk_q, miss_blk_d;
  logic [COUNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
  logic [COUNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;
  logic                   just_filled_q, just_filled_d;

  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             lk_hit;
  logic [31:0]      lk_word;
  logic             fill_en;
  logic             clear_all;
  logic             idle;
  logic             unused_addr_bits;

  assign req_off          = ADDRESS[OFF_W+1:2];
  assign req_idx          = ADDRESS[OFF_W+2 +: IDX_W];
  assign req_tag          = ADDRESS[ADDR_WIDTH-1 -: TAG_W];
  assign unused_addr_bits = ^ADDRESS[1:0];

  instr_cache_array #(
    .NUM_BLOCKS      (NUM_BLOCKS),
    .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
    .TAG_W           (TAG_W),
    .IDX_W           (IDX_W),
    .OFF_W           (OFF_W)
  ) u_array (
    .clk        (CLK),
    .rst        (RESET),
    .lk_index   (req_idx),
    .lk_tag     (req_tag),
    .lk_offset  (req_off),
    .lk_hit     (lk_hit),
    .lk_word    (lk_word),
    .fill_en    (fill_en),
    .fill_index (miss_blk_q[IDX_W-1:0]),
    .fill_tag   (miss_blk_q[BLK_W-1:IDX_W]),
    .fill_data  (MEM_READDATA),
    .clear_all  (clear_all)
  );

  // just_filled marks the IDLE cycle that completes a miss so it is not counted as a hit.
  always_comb begin
    state_d       = state_q;
    miss_blk_d    = miss_blk_q;
    hit_cnt_d     = hit_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    just_filled_d = 1'b0;
    fill_en       = 1'b0;
    clear_all     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (FLUSH) begin
          clear_all = 1'b1;
        end else if (READ && !lk_hit) begin
          state_d    = ST_MEM_READ;
          miss_blk_d = {req_tag, req_idx};
          if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + COUNT_WIDTH'(1);
        end else if (READ && !just_filled_q && (hit_cnt_q != '1)) begin
          hit_cnt_d = hit_cnt_q + COUNT_WIDTH'(1);
        end
      end
      ST_MEM_READ: begin
        if (!MEM_BUSYWAIT) begin
          fill_en = 1'b1;
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        state_d       = ST_IDLE;
        just_filled_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= ST_IDLE;
      miss_blk_q    <= '0;
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
      just_filled_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      miss_blk_q    <= miss_blk_d;
      hit_cnt_q     <= hit_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      just_filled_q <= just_filled_d;
    end
  end

  assign idle        = (state_q == ST_IDLE);
  assign BUSYWAIT    = idle ? (READ && (!lk_hit || FLUSH)) : 1'b1;
  assign MEM_READ    = (state_q == ST_MEM_READ);
  assign MEM_ADDRESS = MEM_READ ? miss_blk_q : '0;
  assign INSTRUCTION = (idle && READ && lk_hit) ? lk_word : 32'd0;
  assign HIT_COUNT   = hit_cnt_q;
  assign MISS_COUNT  = miss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_cache.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_instr_cache : randomized self-checking bench with a line-level model   |
// | Revision       : 1.0                                                      |
// +---------------------------------------------------------------------------+
module tb_instr_cache;

  localparam int LAT = 5;

  logic         clk = 1'b0;
  logic         RESET = 1'b1;
  logic         READ = 1'b0;
  logic         FLUSH = 1'b0;
  logic [9:0]   ADDRESS = '0;
  logic         MEM_BUSYWAIT = 1'b1;
  logic [127:0] MEM_READDATA;

  wire [31:0] instr, instr4;
  wire        busy, busy4, mem_read, mem_read4;
  wire [5:0]  mem_addr, mem_addr4;
  wire [15:0] hit_cnt, miss_cnt;
  wire [3:0]  hit4, miss4;

  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;

  logic [31:0] mem_words [256];
  logic        m_valid   [8];
  logic [2:0]  m_tag     [8];
  int          m_hits;
  int          m_misses;

  always #5 clk = ~clk;

  instr_cache dut (
    .CLK(clk), .RESET(RESET), .ADDRESS(ADDRESS), .READ(READ), .FLUSH(FLUSH),
    .INSTRUCTION(instr), .BUSYWAIT(busy), .MEM_READ(mem_read), .MEM_ADDRESS(mem_addr),
    .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT),
    .HIT_COUNT(hit_cnt), .MISS_COUNT(miss_cnt)
  );

  instr_cache #(.COUNT_WIDTH(4)) dut4 (
    .CLK(clk), .RESET(RESET), .ADDRESS(ADDRESS), .READ(READ), .FLUSH(FLUSH),
    .INSTRUCTION(instr4), .BUSYWAIT(busy4), .MEM_READ(mem_read4), .MEM_ADDRESS(mem_addr4),
    .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT),
    .HIT_COUNT(hit4), .MISS_COUNT(miss4)
  );

  // Instruction memory: busy for LAT cycles of each request, then data valid.
  always @(posedge clk) begin
    #1;
    if (mem_read) begin
      MEM_BUSYWAIT = (busy_cnt < LAT);
      busy_cnt++;
    end else begin
      busy_cnt = 0;
      MEM_BUSYWAIT = 1'b1;
    end
  end

  always_comb begin
    MEM_READDATA = '0;
    for (int k = 0; k < 4; k++)
      MEM_READDATA[k*32 +: 32] = mem_words[int'(mem_addr) * 4 + k];
  end

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
  endfunction

  task automatic do_fetch(input logic [9:0] addr);
    int          idx;
    logic [2:0]  tag;
    logic        hit_exp;
    logic [31:0] exp_word;
    int          stall;
    int          mr;
    int          bad_addr;
    idx      = int'(addr[6:4]);
    tag      = addr[9:7];
    hit_exp  = m_valid[idx] && (m_tag[idx] == tag);
    exp_word = mem_words[addr[9:2]];
    ADDRESS  = addr;
    READ     = 1'b1;
    FLUSH    = 1'b0;
    @(negedge clk);
    if (hit_exp) begin
      checks++;
      if (busy !== 1'b0 || instr !== exp_word) begin
        errors++;
        $display("FAIL hit_fetch addr=%h busy=%b instr=%h required busy=0 instr=%h", addr, busy, instr, exp_word);
      end
      checks++;
      if (busy4 !== 1'b0 || instr4 !== exp_word) begin
        errors++;
        $display("FAIL hit_fetch_w4 addr=%h busy=%b instr=%h required busy=0 instr=%h", addr, busy4, instr4, exp_word);
      end
      m_hits++;
    end else begin
      stall = 0; mr = 0; bad_addr = 0;
      while (busy === 1'b1 && stall < 40) begin
        stall++;
        if (mem_read === 1'b1) begin
          mr++;
          if (mem_addr !== addr[9:4] || mem_addr4 !== addr[9:4]) bad_addr++;
        end else if (mem_addr !== 6'd0) begin
          bad_addr++;
        end
        @(negedge clk);
      end
      checks++;
      if (stall != LAT + 3 || mr != LAT + 1) begin
        errors++;
        $display("FAIL miss_timing addr=%h stall=%0d memread=%0d required stall=%0d memread=%0d", addr, stall, mr, LAT + 3, LAT + 1);
      end
      checks++;
      if (bad_addr != 0) begin
        errors++;
        $display("FAIL miss_mem_address addr=%h bad_cycles=%0d required 0 (block %h)", addr, bad_addr, addr[9:4]);
      end
      checks++;
      if (instr !== exp_word || busy4 !== 1'b0 || instr4 !== exp_word) begin
        errors++;
        $display("FAIL miss_word addr=%h instr=%h instr4=%h required %h", addr, instr, instr4, exp_word);
      end
      m_misses++;
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
    end
    @(posedge clk);
    #1;
    checks++;
    if (hit_cnt !== 16'(sat(m_hits, 16)) || miss_cnt !== 16'(sat(m_misses, 16))) begin
      errors++;
      $display("FAIL counters hit=%0d miss=%0d required hit=%0d miss=%0d", hit_cnt, miss_cnt, sat(m_hits, 16), sat(m_misses, 16));
    end
    checks++;
    if (hit4 !== 4'(sat(m_hits, 4)) || miss4 !== 4'(sat(m_misses, 4))) begin
      errors++;
      $display("FAIL counters_w4 hit=%0d miss=%0d required hit=%0d miss=%0d", hit4, miss4, sat(m_hits, 4), sat(m_misses, 4));
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; READ = 1'b0; FLUSH = 1'b0; ADDRESS = '0;
    repeat (2) @(posedge clk);
    #1;
    RESET = 1'b0;
    model_clear();
    m_hits = 0; m_misses = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || instr !== 32'd0 || mem_read !== 1'b0 || mem_addr !== 6'd0) begin
      errors++;
      $display("FAIL reset_outputs busy=%b instr=%h memread=%b memaddr=%h required 0 0 0 0", busy, instr, mem_read, mem_addr);
    end
    checks++;
    if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0 || hit4 !== 4'd0 || miss4 !== 4'd0) begin
      errors++;
      $display("FAIL reset_counters hit=%0d miss=%0d required 0 0", hit_cnt, miss_cnt);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill_and_hits();
    do_fetch(10'h000);
    do_fetch(10'h004);
    do_fetch(10'h008);
    do_fetch(10'h00C);
  endtask

  task automatic test_conflict();
    do_fetch(10'h080);
    do_fetch(10'h084);
    do_fetch(10'h000);
  endtask

  task automatic test_flush();
    ADDRESS = 10'h004; READ = 1'b1; FLUSH = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || mem_read !== 1'b0) begin
      errors++;
      $display("FAIL flush_cycle busy=%b memread=%b required busy=1 memread=0", busy, mem_read);
    end
    @(posedge clk);
    #1;
    FLUSH = 1'b0;
    model_clear();
    do_fetch(10'h004);
  endtask

  task automatic test_reset_mid_fill();
    ADDRESS = 10'h100; READ = 1'b1; FLUSH = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (mem_read !== 1'b1) begin
      errors++;
      $display("FAIL mid_fill_memread memread=%b required 1", mem_read);
    end
    RESET = 1'b1; READ = 1'b0;
    @(posedge clk); #1;
    RESET = 1'b0;
    model_clear();
    m_hits = 0; m_misses = 0;
    checks++;
    if (mem_read !== 1'b0 || busy !== 1'b0 || instr !== 32'd0 || hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
      errors++;
      $display("FAIL mid_fill_reset memread=%b busy=%b instr=%h hit=%0d miss=%0d required all 0",
               mem_read, busy, instr, hit_cnt, miss_cnt);
    end
    do_fetch(10'h000);
  endtask

  task automatic test_random();
    logic [9:0] a;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        ADDRESS = '0; READ = 1'b0; FLUSH = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || instr !== 32'd0) begin
          errors++;
          $display("FAIL idle_flush busy=%b instr=%h required 0 0", busy, instr);
        end
        @(posedge clk); #1;
        FLUSH = 1'b0;
        model_clear();
      end else begin
        a = 10'($urandom_range(0, 127) * 4);
        do_fetch(a);
      end
    end
  endtask

  task automatic test_saturation();
    logic [9:0] a;
    RESET = 1'b1; READ = 1'b0; FLUSH = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    RESET = 1'b0;
    model_clear();
    m_hits = 0; m_misses = 0;
    do_fetch(10'h000);
    for (int n = 0; n < 20; n++) begin
      a = 10'($urandom_range(0, 3) * 4);
      do_fetch(a);
    end
    checks++;
    if (hit4 !== 4'hF || miss4 !== 4'd1 || hit_cnt !== 16'd20) begin
      errors++;
      $display("FAIL saturation hit4=%h miss4=%0d hit16=%0d required F 1 20", hit4, miss4, hit_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_words[i] = $urandom;
    model_clear();
    m_hits = 0;
    m_misses = 0;
    test_reset();
    test_fill_and_hits();
    test_conflict();
    test_flush();
    test_reset_mid_fill();
    test_random();
    test_saturation();
    READ = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
